// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: double-buffered digit codes,
// per-slot blanking gap, optional leading-zero suppression.
//
// state | meaning
// BLANK | gap between digits, all enables off, seg_code = 1F
// SHOW  | digit idx enabled, seg_code = its effective code
module display_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int AW           = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [4:0]            wr_code,
   input  logic                  wr_commit,
   input  logic                  lz_en,
   input  logic                  blank_all,
   output logic [4:0]            seg_code,
   output logic [NUM_DIGITS-1:0] digit_en_n,
   output logic                  frame_start,
   output logic                  commit_busy
);

   localparam int SHOW_CYCLES = CLK_DIV - BLANK_CYCLES;
   localparam int CW          = $clog2(CLK_DIV + 1);
   localparam logic [4:0] CODE_OFF = 5'h1F;
   localparam logic [NUM_DIGITS-1:0] ALL_OFF = '1;

   typedef enum logic {BLANK, SHOW} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [AW-1:0]         idx;
   logic [AW-1:0]         idx_next;
   logic [4:0]            shadow  [NUM_DIGITS];
   logic [4:0]            display [NUM_DIGITS];
   logic [4:0]            code_hold;
   logic [4:0]            eff_code;
   logic                  pending;
   logic [NUM_DIGITS-1:0] zero_from;
   logic [NUM_DIGITS-1:0] en_idx;
   logic                  blank_done;
   logic                  show_done;
   logic                  wr_ok;
   logic                  run_zero;

   // zero_from[i]: every display digit from i up to the MSD is zero
   always_comb begin
      run_zero  = 1'b1;
      zero_from = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run_zero     = run_zero && (display[i] == 5'd0);
         zero_from[i] = run_zero;
      end
   end

   assign eff_code   = (lz_en && (idx != '0) && zero_from[idx]) ? CODE_OFF : display[idx];
   assign en_idx     = ~(NUM_DIGITS'(1) << idx);
   assign idx_next   = (idx == AW'(NUM_DIGITS - 1)) ? '0 : idx + AW'(1);
   assign blank_done = (state == BLANK) && (cnt == CW'(BLANK_CYCLES - 1));
   assign show_done  = (state == SHOW) && (cnt == CW'(SHOW_CYCLES - 1));
   assign wr_ok      = wr_en && (int'(wr_addr) < NUM_DIGITS);
   assign commit_busy = pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BLANK;
         cnt         <= '0;
         idx         <= '0;
         code_hold   <= CODE_OFF;
         seg_code    <= CODE_OFF;
         digit_en_n  <= ALL_OFF;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            BLANK: begin
               seg_code   <= CODE_OFF;
               digit_en_n <= ALL_OFF;
               if (blank_done) begin
                  state     <= SHOW;
                  cnt       <= '0;
                  code_hold <= eff_code;
                  if (!blank_all) begin
                     seg_code   <= eff_code;
                     digit_en_n <= en_idx;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SHOW: begin
               if (show_done) begin
                  state       <= BLANK;
                  cnt         <= '0;
                  idx         <= idx_next;
                  frame_start <= (idx_next == '0);
                  seg_code    <= CODE_OFF;
                  digit_en_n  <= ALL_OFF;
               end else begin
                  cnt <= cnt + CW'(1);
                  // code_hold keeps lz_en/display fixed for the whole slot
                  if (blank_all) begin
                     seg_code   <= CODE_OFF;
                     digit_en_n <= ALL_OFF;
                  end else begin
                     seg_code   <= code_hold;
                     digit_en_n <= en_idx;
                  end
               end
            end
            default: begin
               state <= BLANK;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow[i]  <= '0;
            display[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            shadow[wr_addr] <= wr_code;
         end
         // copy sees pre-write shadow; a commit on this edge re-arms for next frame
         if (frame_start && pending) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               display[i] <= shadow[i];
            end
            pending <= wr_commit;
         end else if (wr_commit) begin
            pending <= 1'b1;
         end
      end
   end

endmodule
